// File: rtl/psum_pkg.sv
// Shared constants, FSM state type and saturating adder for the psum drain path.
package psum_pkg;

    localparam int NUM_COLS  = 14;
    localparam int DATA_W    = 16;
    localparam int ACC_DEPTH = 256;
    localparam int ADDR_W    = 8;
    localparam int COL_W     = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Signed add clamped to the DATA_W range instead of wrapping.
    function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        logic [DATA_W:0] sum;
        sum = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        if (sum[DATA_W] != sum[DATA_W-1])
            return sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        return sum[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/psum_acc_bank.sv
// One column of psum scratch: read-modify-write accumulate port plus a registered read port.
module psum_acc_bank
    import psum_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    input  logic              overwrite,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem [ACC_DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= overwrite ? din : sat_add(mem[addr], din);
        dout <= mem[raddr];
    end

endmodule

// File: rtl/psum_collector.sv
// Collects bottom-row psums across channel passes and drains the finished ofmap tile.
module psum_collector
    import psum_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       psum_valid,
    input  logic [NUM_COLS*DATA_W-1:0] psum_in,
    input  logic                       first_pass,
    input  logic                       last_pass,
    input  logic [ADDR_W-1:0]          pass_len,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [COL_W-1:0]           out_col,
    output logic [ADDR_W-1:0]          out_addr,
    output logic                       busy,
    output logic                       drain_done,
    output logic                       overflow_err
);

    state_t            state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_addr;
    logic [COL_W-1:0]  rd_col;
    logic              lat_first;
    logic              lat_last;
    logic [ADDR_W-1:0] lat_len;

    logic              eff_first;
    logic              eff_last;
    logic [ADDR_W-1:0] eff_len;
    logic              bank_we;
    logic              pass_end;
    logic              xfer;
    logic              col_wrap;
    logic [ADDR_W-1:0] rd_raddr;
    logic [DATA_W-1:0] bank_dout [NUM_COLS];

    // The first beat of a pass uses the live controls; later beats use the latched copy.
    always_comb begin
        eff_first = (state == IDLE) ? first_pass : lat_first;
        eff_last  = (state == IDLE) ? last_pass  : lat_last;
        eff_len   = (state == IDLE) ? pass_len   : lat_len;
        bank_we   = psum_valid && (state != DRAIN);
        pass_end  = bank_we && (wr_ptr == eff_len - ADDR_W'(1));
        xfer      = (state == DRAIN) && out_valid && out_ready;
        col_wrap  = (rd_col == COL_W'(NUM_COLS - 1));
        // Read address runs one step ahead so a new row is ready right after the column wrap.
        rd_raddr  = (xfer && col_wrap) ? rd_addr + ADDR_W'(1) : rd_addr;
    end

    for (genvar c = 0; c < NUM_COLS; c++) begin : g_bank
        psum_acc_bank u_bank (
            .clk       (clk),
            .we        (bank_we),
            .addr      (wr_ptr),
            .din       (psum_in[c*DATA_W +: DATA_W]),
            .overwrite (eff_first),
            .raddr     (rd_raddr),
            .dout      (bank_dout[c])
        );
    end

    always_comb begin
        out_data = '0;
        if (rd_col < COL_W'(NUM_COLS))
            out_data = bank_dout[rd_col];
    end

    assign out_col  = rd_col;
    assign out_addr = rd_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_addr      <= '0;
            rd_col       <= '0;
            lat_first    <= 1'b0;
            lat_last     <= 1'b0;
            lat_len      <= '0;
            out_valid    <= 1'b0;
            busy         <= 1'b0;
            drain_done   <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            drain_done <= 1'b0;
            case (state)
                IDLE, ACCUM: begin
                    if (psum_valid) begin
                        if (state == IDLE) begin
                            lat_first <= first_pass;
                            lat_last  <= last_pass;
                            lat_len   <= pass_len;
                        end
                        if (pass_end) begin
                            wr_ptr <= '0;
                            state  <= eff_last ? DRAIN : IDLE;
                            busy   <= eff_last;
                        end else begin
                            wr_ptr <= wr_ptr + ADDR_W'(1);
                            state  <= ACCUM;
                            busy   <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (psum_valid)
                        overflow_err <= 1'b1;
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        if (col_wrap) begin
                            rd_col <= '0;
                            if (rd_addr == lat_len - ADDR_W'(1)) begin
                                rd_addr    <= '0;
                                out_valid  <= 1'b0;
                                drain_done <= 1'b1;
                                busy       <= 1'b0;
                                state      <= IDLE;
                            end else begin
                                rd_addr <= rd_addr + ADDR_W'(1);
                            end
                        end else begin
                            rd_col <= rd_col + COL_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_psum_collector.sv
// Directed bench for psum_collector: accumulate, saturate, backpressure, overflow and reset cases.
module tb_psum_collector;
    import psum_pkg::*;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       psum_valid;
    logic [NUM_COLS*DATA_W-1:0] psum_in;
    logic                       first_pass;
    logic                       last_pass;
    logic [ADDR_W-1:0]          pass_len;
    logic                       out_valid;
    logic                       out_ready;
    logic [DATA_W-1:0]          out_data;
    logic [COL_W-1:0]           out_col;
    logic [ADDR_W-1:0]          out_addr;
    logic                       busy;
    logic                       drain_done;
    logic                       overflow_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    psum_collector dut (
        .clk          (clk),
        .rst          (rst),
        .psum_valid   (psum_valid),
        .psum_in      (psum_in),
        .first_pass   (first_pass),
        .last_pass    (last_pass),
        .pass_len     (pass_len),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_col      (out_col),
        .out_addr     (out_addr),
        .busy         (busy),
        .drain_done   (drain_done),
        .overflow_err (overflow_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: psum(col c, beat a) = 16*a + c; otherwise every lane carries cval.
    task automatic send_pass(input int len, input bit first, input bit last,
                             input int mode, input logic [15:0] cval);
        for (int a = 0; a < len; a++) begin
            psum_valid = 1'b1;
            first_pass = (a == 0) ? first : ~first;
            last_pass  = (a == 0) ? last  : ~last;
            pass_len   = (a == 0) ? 8'(len) : 8'(len + 3);
            for (int c = 0; c < NUM_COLS; c++)
                psum_in[c*DATA_W +: DATA_W] = (mode == 0) ? 16'(16*a + c) : cval;
            tick();
            chk("busy_in_pass", 32'(busy), 32'((a < len-1) || last));
        end
        psum_valid = 1'b0;
        first_pass = 1'b0;
        last_pass  = 1'b0;
    endtask

    // rmode 0: ready held high; rmode 1: low 10 cycles then random.
    task automatic drain(input int len, input int mode, input logic [15:0] cval,
                         input int rmode, input int inject_at);
        int k;
        int cyc;
        bit stalled;
        bit rdy;
        logic [28:0] held;
        int total;
        total   = len * NUM_COLS;
        k       = 0;
        cyc     = 0;
        stalled = 1'b0;
        held    = '0;
        while (k < total && cyc < 3000) begin
            if (stalled)
                chk("hold_stable", 32'({out_valid, out_data, out_col, out_addr}), 32'(held));
            rdy = (rmode == 0) ? 1'b1 : ((cyc < 10) ? 1'b0 : 1'($urandom_range(0, 1)));
            out_ready  = rdy;
            psum_valid = (cyc == inject_at);
            if (cyc == inject_at)
                for (int c = 0; c < NUM_COLS; c++)
                    psum_in[c*DATA_W +: DATA_W] = 16'h1111;
            stalled = 1'b0;
            if (out_valid) begin
                if (rdy) begin
                    chk("out_addr", 32'(out_addr), 32'(k / NUM_COLS));
                    chk("out_col",  32'(out_col),  32'(k % NUM_COLS));
                    chk("out_data", 32'(out_data),
                        (mode == 0) ? 32'(16*(k / NUM_COLS) + (k % NUM_COLS)) : 32'(cval));
                    k++;
                end else begin
                    stalled = 1'b1;
                    held    = {out_valid, out_data, out_col, out_addr};
                end
            end
            tick();
            cyc++;
        end
        psum_valid = 1'b0;
        if (k < total)
            chk("drain_timeout", 32'(k), 32'(total));
        chk("drain_done_pulse", 32'(drain_done), 32'd1);
        chk("valid_after_drain", 32'(out_valid), 32'd0);
        chk("busy_after_drain", 32'(busy), 32'd0);
        tick();
        chk("drain_done_clear", 32'(drain_done), 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        psum_valid = 1'b0;
        psum_in    = '0;
        first_pass = 1'b0;
        last_pass  = 1'b0;
        pass_len   = '0;
        out_ready  = 1'b0;
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_drain_done", 32'(drain_done), 32'd0);
        chk("rst_overflow", 32'(overflow_err), 32'd0);
        chk("rst_out_col", 32'(out_col), 32'd0);
        chk("rst_out_addr", 32'(out_addr), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // 1: single pass, in-order drain
        send_pass(4, 1'b1, 1'b1, 0, 16'h0);
        drain(4, 0, 16'h0, 0, -1);

        // 2: three accumulating passes 1+2+3
        send_pass(2, 1'b1, 1'b0, 1, 16'd1);
        send_pass(2, 1'b0, 1'b0, 1, 16'd2);
        send_pass(2, 1'b0, 1'b1, 1, 16'd3);
        drain(2, 1, 16'd6, 0, -1);

        // 3: saturation corners
        send_pass(1, 1'b1, 1'b0, 1, 16'h7000);
        send_pass(1, 1'b0, 1'b1, 1, 16'h7000);
        drain(1, 1, 16'h7FFF, 0, -1);
        send_pass(1, 1'b1, 1'b0, 1, 16'h9000);
        send_pass(1, 1'b0, 1'b1, 1, 16'h9000);
        drain(1, 1, 16'h8000, 0, -1);
        send_pass(1, 1'b1, 1'b0, 1, 16'h7FFF);
        send_pass(1, 1'b0, 1'b1, 1, 16'hFFFF);
        drain(1, 1, 16'h7FFE, 0, -1);
        chk("no_overflow_yet", 32'(overflow_err), 32'd0);

        // 4: backpressure
        send_pass(4, 1'b1, 1'b1, 0, 16'h0);
        drain(4, 0, 16'h0, 1, -1);
        chk("no_overflow_bp", 32'(overflow_err), 32'd0);

        // 5: psum beat during drain is dropped and flagged
        send_pass(4, 1'b1, 1'b1, 0, 16'h0);
        drain(4, 0, 16'h0, 0, 5);
        chk("overflow_set", 32'(overflow_err), 32'd1);
        tick();
        chk("overflow_sticky", 32'(overflow_err), 32'd1);

        // 6: reset mid-drain, then a fresh single-beat pass
        out_ready = 1'b1;
        send_pass(4, 1'b1, 1'b1, 0, 16'h0);
        for (int i = 0; i < 5; i++)
            tick();
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_overflow", 32'(overflow_err), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        send_pass(1, 1'b1, 1'b1, 1, 16'd5);
        drain(1, 1, 16'd5, 0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
